// File: rtl/block_looper_nch_if.sv
// Handshake/bus bundle between the block looper, the task configuration
// front end, the block-offset consumer, the per-channel memory-offset
// consumers and the block-completion reporter.
//
// Signals:
//   src_rdy / src_ack   task request (held until ack) / task retired pulse
//   i_bgrid_last        last block index per dimension, dim d at [d*WBW +: WBW]
//   i_ch_en             channel enable mask
//   i_mofs_start        per-channel base offset, channel c at [c*GBW +: GBW]
//   i_mofs_step         per-channel, per-dimension stride,
//                       (c,d) at [(c*DIM+d)*GBW +: GBW]
//   bofs_rdy/ack/o_bofs block-offset stream (dim d at [d*WBW +: WBW])
//   mofs_rdy/ack/o_mofs per-channel memory-offset streams
//   blkdone_dval        one issued block has completed downstream
//
// Modports: slave = the looper, master = the surrounding system.
interface block_looper_nch_if #(
  parameter int DIM  = 4,
  parameter int WBW  = 16,
  parameter int GBW  = 32,
  parameter int N_CH = 3
);
  logic                    src_rdy;
  logic                    src_ack;
  logic [DIM*WBW-1:0]      i_bgrid_last;
  logic [N_CH-1:0]         i_ch_en;
  logic [N_CH*GBW-1:0]     i_mofs_start;
  logic [N_CH*DIM*GBW-1:0] i_mofs_step;
  logic                    bofs_rdy;
  logic                    bofs_ack;
  logic [DIM*WBW-1:0]      o_bofs;
  logic [N_CH-1:0]         mofs_rdy;
  logic [N_CH-1:0]         mofs_ack;
  logic [N_CH*GBW-1:0]     o_mofs;
  logic                    blkdone_dval;

  modport slave (
    input  src_rdy, i_bgrid_last, i_ch_en, i_mofs_start, i_mofs_step,
           bofs_ack, mofs_ack, blkdone_dval,
    output src_ack, bofs_rdy, o_bofs, mofs_rdy, o_mofs
  );

  modport master (
    output src_rdy, i_bgrid_last, i_ch_en, i_mofs_start, i_mofs_step,
           bofs_ack, mofs_ack, blkdone_dval,
    input  src_ack, bofs_rdy, o_bofs, mofs_rdy, o_mofs
  );
endinterface

// File: rtl/block_looper_nch.sv
// Block looper: walks a DIM-dimensional block grid (dim 0 fastest), broadcasts
// each block index vector on the bofs stream and one incrementally accumulated
// linear memory offset per enabled channel on the mofs streams. Issue is
// throttled so that at most N_PENDING blocks are outstanding (issued but not
// yet reported by blkdone_dval). The task is retired with a one-cycle src_ack
// once the grid is exhausted and every issued block has completed.
//
// Ports:
//   i_clk        clock
//   i_rst        asynchronous, active-low reset
//   bus          block_looper_nch_if.slave (task, bofs, mofs, blkdone)
//   o_stall_cnt  (only with BLK_LOOPER_PERF_EN) cycles spent in RUN fully
//                throttled with nothing offered; saturating, cleared per task
//
// Optional feature macro: BLK_LOOPER_PERF_EN
module block_looper_nch #(
  parameter int DIM       = 4,
  parameter int WBW       = 16,
  parameter int GBW       = 32,
  parameter int N_CH      = 3,
  parameter int N_PENDING = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  block_looper_nch_if.slave   bus
`ifdef BLK_LOOPER_PERF_EN
  ,
  output logic [31:0]         o_stall_cnt
`endif
);

  localparam int PW = $clog2(N_PENDING + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(N_PENDING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;

  // Task configuration, captured once when the task is accepted.
  logic [WBW-1:0]  last_q [DIM];
  logic [N_CH-1:0] en_q;
  logic [GBW-1:0]  step_q [N_CH][DIM];

  // Walk state. acc_q[c][d] holds the channel-c offset at the start of the
  // current dim-d run, so advancing dimension d needs one add and a copy down.
  logic [WBW-1:0]  idx_q [DIM];
  logic [WBW-1:0]  idx_d [DIM];
  logic [GBW-1:0]  acc_q [N_CH][DIM];
  logic [GBW-1:0]  acc_d [N_CH][DIM];
  logic            sent_b_q, sent_b_d;
  logic [N_CH-1:0] sent_q, sent_d;
  logic [PW-1:0]   pend_q, pend_d;

  logic            accept;
  logic            issue;
  logic            bofs_rdy;
  logic [N_CH-1:0] mofs_rdy;
  logic            hs_b;
  logic [N_CH-1:0] hs_m;
  logic            done_b;
  logic [N_CH-1:0] done_m;
  logic            blk_done;
  logic            dec;
  logic            found;
  logic            all_last;
  int              sel;
  logic [GBW-1:0]  nv;

  assign accept   = (state_q == S_IDLE) && bus.src_rdy;
  // Pending only grows on completion, so an offered block is never withdrawn.
  assign issue    = (state_q == S_RUN) && (pend_q < PEND_MAX);
  assign bofs_rdy = issue & ~sent_b_q;
  assign mofs_rdy = {N_CH{issue}} & en_q & ~sent_q;
  assign hs_b     = bofs_rdy & bus.bofs_ack;
  assign hs_m     = mofs_rdy & bus.mofs_ack;
  // Disabled channels count as already sent.
  assign done_b   = sent_b_q | hs_b;
  assign done_m   = ~en_q | sent_q | hs_m;
  assign blk_done = issue & done_b & (&done_m);
  // A completion report with nothing outstanding is dropped.
  assign dec      = bus.blkdone_dval && (pend_q != '0);

  assign bus.bofs_rdy = bofs_rdy;
  assign bus.mofs_rdy = mofs_rdy;
  assign bus.src_ack  = (state_q == S_DRAIN) && (pend_q == '0);

  always_comb begin
    bus.o_bofs = '0;
    bus.o_mofs = '0;
    for (int d = 0; d < DIM; d++) bus.o_bofs[d*WBW +: WBW] = idx_q[d];
    for (int c = 0; c < N_CH; c++) bus.o_mofs[c*GBW +: GBW] = acc_q[c][0];
  end

  // Lowest dimension that has not reached its last index yet.
  always_comb begin
    found = 1'b0;
    sel   = 0;
    for (int d = 0; d < DIM; d++) begin
      if (!found && (idx_q[d] != last_q[d])) begin
        found = 1'b1;
        sel   = d;
      end
    end
    all_last = !found;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    sent_b_d = sent_b_q;
    sent_d   = sent_q;
    nv       = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.src_rdy) begin
          state_d  = S_RUN;
          sent_b_d = 1'b0;
          sent_d   = '0;
          for (int d = 0; d < DIM; d++) begin
            idx_d[d] = '0;
            for (int c = 0; c < N_CH; c++) acc_d[c][d] = bus.i_mofs_start[c*GBW +: GBW];
          end
        end
      end
      S_RUN: begin
        if (blk_done) begin
          sent_b_d = 1'b0;
          sent_d   = '0;
          if (all_last) begin
            state_d = S_DRAIN;
          end else begin
            for (int d = 0; d < DIM; d++) begin
              if (d < sel)       idx_d[d] = '0;
              else if (d == sel) idx_d[d] = idx_q[d] + 1'b1;
            end
            for (int c = 0; c < N_CH; c++) begin
              for (int d = 0; d < DIM; d++) begin
                if (d == sel) nv = acc_q[c][d] + step_q[c][d];
              end
              for (int d = 0; d < DIM; d++) begin
                if (d <= sel) acc_d[c][d] = nv;
              end
            end
          end
        end else begin
          sent_b_d = sent_b_q | hs_b;
          sent_d   = sent_q | hs_m;
        end
      end
      S_DRAIN: begin
        if (pend_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (blk_done && !dec)      pend_d = pend_q + 1'b1;
    else if (!blk_done && dec) pend_d = pend_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      sent_b_q <= 1'b0;
      sent_q   <= '0;
      pend_q   <= '0;
      for (int d = 0; d < DIM; d++) begin
        idx_q[d] <= '0;
        for (int c = 0; c < N_CH; c++) acc_q[c][d] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sent_b_q <= sent_b_d;
      sent_q   <= sent_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

  // Configuration holds no meaning outside a task, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      en_q <= bus.i_ch_en;
      for (int d = 0; d < DIM; d++) begin
        last_q[d] <= bus.i_bgrid_last[d*WBW +: WBW];
        for (int c = 0; c < N_CH; c++) step_q[c][d] <= bus.i_mofs_step[(c*DIM+d)*GBW +: GBW];
      end
    end
  end

`ifdef BLK_LOOPER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && (pend_q == PEND_MAX) && !bofs_rdy &&
                 !(|mofs_rdy) && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_block_looper_nch.sv
module tb_block_looper_nch;
  localparam int DIM = 2, WBW = 16, GBW = 32, N_CH = 3, N_PENDING = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  block_looper_nch_if #(.DIM(DIM), .WBW(WBW), .GBW(GBW), .N_CH(N_CH)) bus();

`ifdef BLK_LOOPER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  block_looper_nch #(.DIM(DIM), .WBW(WBW), .GBW(GBW), .N_CH(N_CH), .N_PENDING(N_PENDING)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
`ifdef BLK_LOOPER_PERF_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Consumer models: each ack rises dly cycles after its rdy rose.
  int         dly_b = 0;
  int         dly_m [3] = '{0, 0, 0};
  logic [7:0] wait_b = 8'd0;
  logic [7:0] wait_m [3] = '{8'd0, 8'd0, 8'd0};
  logic [2:0] ack_m;
  logic [1:0] bd_pipe = 2'b00;
  logic       auto_bd = 1'b0;
  logic       man_bd  = 1'b0;

  always @(posedge i_clk) begin
    wait_b <= (bus.bofs_rdy && !bus.bofs_ack) ? wait_b + 8'd1 : 8'd0;
    for (int c = 0; c < 3; c++)
      wait_m[c] <= (bus.mofs_rdy[c] && !ack_m[c]) ? wait_m[c] + 8'd1 : 8'd0;
    bd_pipe <= {bd_pipe[0], bus.bofs_rdy & bus.bofs_ack};
  end

  always_comb begin
    ack_m = '0;
    for (int c = 0; c < 3; c++) ack_m[c] = bus.mofs_rdy[c] && (int'(wait_m[c]) >= dly_m[c]);
  end

  assign bus.bofs_ack     = bus.bofs_rdy && (int'(wait_b) >= dly_b);
  assign bus.mofs_ack     = ack_m;
  assign bus.blkdone_dval = auto_bd ? bd_pipe[1] : man_bd;

  // Scoreboard and observation state.
  logic [31:0] exp_b [$];
  logic [31:0] exp_m0 [$];
  logic [31:0] exp_m1 [$];
  logic [31:0] exp_m2 [$];
  logic [31:0] cfg_start [3];
  logic [31:0] cfg_step [3][2];
  logic [2:0]  en_cfg = 3'b000;
  logic        dis_seen = 1'b0;
  int cyc = 0, hs_b = 0, n_src_ack = 0, n_bd = 0, bd_at_ack = 0;
  int hs_m [3] = '{0, 0, 0};
  int hs_cyc_prev = 0, hs_cyc_last = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // An unexpected transfer compares against a value no output can carry.
  task automatic pop_chk(input string tag, input int which, input logic [31:0] obs);
    logic [63:0] e;
    e = 64'hFFFF_FFFF_FFFF_FFFF;
    case (which)
      0: if (exp_b.size()  > 0) e = {32'h0, exp_b.pop_front()};
      1: if (exp_m0.size() > 0) e = {32'h0, exp_m0.pop_front()};
      2: if (exp_m1.size() > 0) e = {32'h0, exp_m1.pop_front()};
      default: if (exp_m2.size() > 0) e = {32'h0, exp_m2.pop_front()};
    endcase
    check(tag, {32'h0, obs}, e);
  endtask

  task automatic monitor();
    cyc++;
    if (bus.bofs_rdy && bus.bofs_ack) begin
      hs_b++;
      hs_cyc_prev = hs_cyc_last;
      hs_cyc_last = cyc;
      pop_chk("bofs", 0, bus.o_bofs);
    end
    for (int c = 0; c < 3; c++) begin
      if (bus.mofs_rdy[c] && bus.mofs_ack[c]) begin
        hs_m[c]++;
        pop_chk($sformatf("mofs%0d", c), c + 1, bus.o_mofs[c*32 +: 32]);
      end
    end
    if ((bus.mofs_rdy & ~en_cfg) != 3'b000) dis_seen = 1'b1;
    if (bus.src_ack) begin
      n_src_ack++;
      bd_at_ack = n_bd;
    end
    if (bus.blkdone_dval) n_bd++;
  endtask

  task automatic tick();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_task(input logic [15:0] l0, input logic [15:0] l1, input logic [2:0] en);
    logic [31:0] v;
    bus.i_bgrid_last = {l1, l0};
    bus.i_ch_en      = en;
    en_cfg           = en;
    for (int c = 0; c < 3; c++) begin
      bus.i_mofs_start[c*32 +: 32] = cfg_start[c];
      for (int d = 0; d < 2; d++) bus.i_mofs_step[(c*2+d)*32 +: 32] = cfg_step[c][d];
    end
    for (int i1 = 0; i1 <= int'(l1); i1++) begin
      for (int i0 = 0; i0 <= int'(l0); i0++) begin
        exp_b.push_back({16'(i1), 16'(i0)});
        for (int c = 0; c < 3; c++) begin
          v = cfg_start[c] + 32'(i0) * cfg_step[c][0] + 32'(i1) * cfg_step[c][1];
          if (en[c]) begin
            if (c == 0) exp_m0.push_back(v);
            else if (c == 1) exp_m1.push_back(v);
            else exp_m2.push_back(v);
          end
        end
      end
    end
    bus.src_rdy = 1'b1;
    tick();
    // Configuration must have been captured; scramble the inputs.
    bus.i_bgrid_last = $urandom;
    bus.i_ch_en      = 3'($urandom);
    bus.i_mofs_start = {$urandom, $urandom, $urandom};
    bus.i_mofs_step  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int  base;
    bit  got;
    base = n_src_ack;
    got  = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (bus.src_ack) got = 1'b1;
      else tick();
    end
    if (got) tick();
    bus.src_rdy = 1'b0;
    check({tag, "_src_ack_seen"}, 64'(got), 64'd1);
    tick();
    tick();
    check({tag, "_src_ack_pulses"}, 64'(n_src_ack - base), 64'd1);
    check({tag, "_bofs_left"}, 64'(exp_b.size()), 64'd0);
    check({tag, "_mofs_left"}, 64'(exp_m0.size() + exp_m1.size() + exp_m2.size()), 64'd0);
  endtask

  int base_b, base_m1, base_bd;

  initial begin
    bus.src_rdy      = 1'b0;
    bus.i_bgrid_last = '0;
    bus.i_ch_en      = '0;
    bus.i_mofs_start = '0;
    bus.i_mofs_step  = '0;
    cfg_start = '{32'd100, 32'd7, 32'hFFFF_FFF0};
    cfg_step  = '{'{32'd4, 32'd64}, '{32'd1, 32'd10}, '{32'h10, 32'h100}};

    // Reset state.
    tick(); tick();
    check("rst_bofs_rdy", 64'(bus.bofs_rdy), 64'd0);
    check("rst_mofs_rdy", 64'(bus.mofs_rdy), 64'd0);
    check("rst_src_ack",  64'(bus.src_ack),  64'd0);
    check("rst_o_bofs",   64'(bus.o_bofs),   64'd0);
    check("rst_o_mofs",   64'(bus.o_mofs),   64'd0);
    i_rst = 1'b1;
    tick();

    // 2x3 grid, all channels, immediate acks, blkdone two cycles after issue.
    auto_bd = 1'b1;
    base_bd = n_bd;
    start_task(16'd1, 16'd2, 3'b111);
    wait_ack("t1", 200);
    check("t1_blkdone_before_ack", 64'(bd_at_ack - base_bd), 64'd6);
    auto_bd = 1'b0;

    // Throttle: blkdone withheld, two blocks then stall; one pulse frees one.
    base_b = hs_b;
    start_task(16'd1, 16'd2, 3'b111);
    repeat (6) tick();
    check("t2_issued_at_full", 64'(hs_b - base_b), 64'd2);
    check("t2_rdy_low_at_full", 64'(bus.bofs_rdy), 64'd0);
    man_bd = 1'b1;
    tick();
    man_bd = 1'b0;
    check("t2_blk3_rdy_next_cycle", 64'(bus.bofs_rdy), 64'd1);
    man_bd = 1'b1;
    wait_ack("t2", 200);
    man_bd = 1'b0;

    // Channel mask 010 with channel 1 acking five cycles late.
    dly_m[1] = 5;
    dis_seen = 1'b0;
    base_b   = hs_b;
    base_m1  = hs_m[1];
    start_task(16'd2, 16'd0, 3'b010);
    repeat (30) tick();
    check("t3_issued_at_full", 64'(hs_b - base_b), 64'd2);
    check("t3_ch1_transfers", 64'(hs_m[1] - base_m1), 64'd2);
    check("t3_block_spacing", 64'(hs_cyc_last - hs_cyc_prev), 64'd6);
    check("t3_rdy_low_at_full", 64'(bus.bofs_rdy), 64'd0);
    man_bd = 1'b1;
    wait_ack("t3", 200);
    man_bd = 1'b0;
    check("t3_disabled_rdy_seen", 64'(dis_seen), 64'd0);
    dly_m[1] = 0;

    // blkdone at pending 0 is ignored; blkdone with a completion at pending 1 holds.
    man_bd = 1'b1;
    tick();
    man_bd = 1'b0;
    base_b = hs_b;
    start_task(16'd1, 16'd2, 3'b111);
    tick();
    man_bd = 1'b1;
    tick();
    man_bd = 1'b0;
    repeat (6) tick();
    check("t4_issued_with_coincident_done", 64'(hs_b - base_b), 64'd3);
    check("t4_rdy_low_at_full", 64'(bus.bofs_rdy), 64'd0);
    man_bd = 1'b1;
    wait_ack("t4", 200);
    man_bd = 1'b0;

    // Modulo wrap on an all-ones stride.
    cfg_start = '{32'd0, 32'd5, 32'd9};
    cfg_step  = '{'{32'hFFFF_FFFF, 32'd0}, '{32'd3, 32'd0}, '{32'hFFFF_FFFE, 32'd0}};
    auto_bd = 1'b1;
    start_task(16'd3, 16'd0, 3'b111);
    wait_ack("t5", 200);
    auto_bd = 1'b0;

    // Asynchronous reset while a block is offered and one is pending.
    dly_b  = 3;
    base_b = hs_b;
    start_task(16'd2, 16'd0, 3'b111);
    for (int i = 0; i < 20 && (hs_b - base_b) < 1; i++) tick();
    check("t6_rdy_before_rst", 64'(bus.bofs_rdy), 64'd1);
    i_rst = 1'b0;
    #1;
    check("t6_rst_bofs_rdy", 64'(bus.bofs_rdy), 64'd0);
    check("t6_rst_mofs_rdy", 64'(bus.mofs_rdy), 64'd0);
    check("t6_rst_src_ack",  64'(bus.src_ack),  64'd0);
    check("t6_rst_o_bofs",   64'(bus.o_bofs),   64'd0);
    check("t6_rst_o_mofs",   64'(bus.o_mofs),   64'd0);
    bus.src_rdy = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    exp_b.delete();
    exp_m0.delete();
    exp_m1.delete();
    exp_m2.delete();
    dly_b  = 0;
    base_b = hs_b;
    start_task(16'd2, 16'd0, 3'b101);
    repeat (8) tick();
    check("t6_issued_after_rst", 64'(hs_b - base_b), 64'd2);
    check("t6_rdy_low_at_full", 64'(bus.bofs_rdy), 64'd0);
    man_bd = 1'b1;
    wait_ack("t6", 200);
    man_bd = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
